// File: rtl/obstacle_pkg.sv
// Shared types and helpers for the obstacle feeder.
// Holds the run-control states and the LFSR step function.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         LVL_W     = 3;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    if (s[0]) return (s >> 1) ^ LFSR_TAPS;
    else      return s >> 1;
  endfunction

endpackage

// File: rtl/obstacle_feeder_lfsr8.sv
// 8-bit Galois LFSR with synchronous reseed and step enable.
// Reseeding with zero falls back to 1 so the state never locks up.
module lfsr8
  import obstacle_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (seed != 8'h00) ? seed : 8'h01;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/obstacle_feeder.sv
// Paces the obstacle shift register: tick divider, level ramp,
// and LFSR-drawn obstacle bits with an enforced clear gap.
module obstacle_feeder
  import obstacle_pkg::*;
#(
  parameter int         CNT_W            = 24,
  parameter int         BASE_PERIOD      = 12500000,
  parameter int         PERIOD_STEP      = 1000000,
  parameter int         MAX_LEVEL        = 7,
  parameter int         SHIFTS_PER_LEVEL = 32,
  parameter int         MIN_GAP          = 2,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Collision,
  output logic             BitIn,
  output logic             Shift,
  output logic [LVL_W-1:0] Level,
  output logic             Running
);

  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(PERIOD_STEP);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
  localparam int SC_W =
    (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [2:0] GAP_C = 3'(MIN_GAP);

  state_t state;
  state_t state_nx;
  logic   enter_run;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_m1;
  logic [SC_W-1:0]  scnt;
  logic [2:0]       gap;
  logic             tick;
  logic             step;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_nx;
  logic       hit;
  logic       unused_lfsr;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    enter_run = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nx  = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (Collision) state_nx = HALT;
      end
      HALT: begin
        if (Start && !Collision) begin
          state_nx  = RUN;
          enter_run = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Running = (state == RUN);

  // Level is at most MAX_LEVEL, so the period never underflows.
  assign period    = BASE_C - (CNT_W'(Level) * STEP_C);
  assign period_m1 = period - ONE_C;
  assign tick      = Running && !Collision && (cnt == period_m1);
  assign step      = Running && Shift;

  assign lfsr_nx     = lfsr_next(lfsr_q);
  assign hit         = lfsr_nx[0];
  assign unused_lfsr = ^lfsr_nx[7:1];

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (Clk),
    .rst_n (Rst),
    .step  (step),
    .load  (enter_run),
    .seed  (LFSR_SEED),
    .state (lfsr_q)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt   <= '0;
      Shift <= 1'b0;
      BitIn <= 1'b0;
      Level <= '0;
      scnt  <= '0;
      gap   <= '0;
    end else if (enter_run) begin
      cnt   <= '0;
      Shift <= 1'b0;
      BitIn <= 1'b0;
      Level <= '0;
      scnt  <= '0;
      gap   <= '0;
    end else if (Running) begin
      Shift <= tick;
      if (tick)            cnt <= '0;
      else if (!Collision) cnt <= cnt + ONE_C;
      // New bit and level land the cycle after the strobe.
      if (Shift) begin
        if (gap != 3'd0) begin
          BitIn <= 1'b0;
          gap   <= gap - 3'd1;
        end else begin
          BitIn <= hit;
          if (hit) gap <= GAP_C;
        end
        if (scnt == SC_LAST) begin
          scnt <= '0;
          if (Level != LVL_MAX) Level <= Level + 1'b1;
        end else begin
          scnt <= scnt + 1'b1;
        end
      end
    end else begin
      Shift <= 1'b0;
    end
  end

endmodule
